// File: rtl/pc_seq_ctrl_if.sv
// Instruction-fetch handshake between the PC sequencer and instruction memory.
interface pc_seq_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencer for the single-cycle RV32 core: fetch handshake, next-PC
// selection (sequential, redirect, trap, mret), trap state and retire counter.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  output logic [31:0]         pc_next,
  output logic                pc_we,
  pc_seq_ctrl_if.master       imem,
  output logic                instr_valid,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_target,
  input  logic                trap_req,
  input  logic                mret,
  output logic [31:0]         mepc,
  output logic [3:0]          mcause,
  output logic [31:0]         instret
);

  localparam int unsigned   CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_TIMEOUT  = 4'd1;
  localparam logic [3:0] CAUSE_TRAP     = 4'd2;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      mepc_q, mepc_d;
  logic [3:0]       mcause_q, mcause_d;
  logic [31:0]      instret_q, instret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exec_leave;

  // State register and trap/retire bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RST;
      mepc_q    <= '0;
      mcause_q  <= '0;
      instret_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      instret_q <= instret_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and output decode; the counter only survives uninterrupted FETCH cycles
  always_comb begin
    state_d     = state_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    instret_d   = instret_q;
    cnt_d       = '0;
    exec_leave  = 1'b0;
    pc_next     = pc;
    pc_we       = 1'b0;
    imem.req    = 1'b0;
    imem.addr   = '0;
    instr_valid = 1'b0;

    unique case (state_q)
      ST_RST: begin
        pc_we   = 1'b1;
        pc_next = RESET_VECTOR;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem.req  = 1'b1;
        imem.addr = pc;
        if (imem.ack) begin
          state_d = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          mepc_d   = pc;
          mcause_d = CAUSE_TIMEOUT;
          pc_next  = TRAP_VECTOR;
          pc_we    = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end

      ST_EXEC: begin
        instr_valid = 1'b1;
        exec_leave  = 1'b1;
        if (trap_req) begin
          mepc_d   = pc;
          mcause_d = CAUSE_TRAP;
          pc_next  = TRAP_VECTOR;
        end else if (mret) begin
          pc_next   = mepc_q;
          instret_d = 32'(instret_q + 32'd1);
        end else if (redirect) begin
          if (redirect_target[1:0] != 2'b00) begin
            mepc_d   = pc;
            mcause_d = CAUSE_MISALIGN;
            pc_next  = TRAP_VECTOR;
          end else begin
            pc_next   = redirect_target;
            instret_d = 32'(instret_q + 32'd1);
          end
        end else if (stall) begin
          exec_leave = 1'b0;
        end else begin
          pc_next   = 32'(pc + 32'd4);
          instret_d = 32'(instret_q + 32'd1);
        end
        if (exec_leave) begin
          pc_we   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_RST;
    endcase

    // Reset forces every output quiet, with pc_reg holding its value
    if (reset) begin
      pc_next     = pc;
      pc_we       = 1'b0;
      imem.req    = 1'b0;
      imem.addr   = '0;
      instr_valid = 1'b0;
    end
  end

  assign mepc    = reset ? 32'd0 : mepc_q;
  assign mcause  = reset ? 4'd0  : mcause_q;
  assign instret = reset ? 32'd0 : instret_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: stimulus pushes the expected next fetch,
// a monitor pops and compares at every fetch start.
module tb_pc_seq_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] mepc;
    logic [3:0]  mcause;
    logic [31:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        instr_valid;
  logic        stall, redirect, trap_req, mret;
  logic [31:0] redirect_target;
  logic [31:0] mepc;
  logic [3:0]  mcause;
  logic [31:0] instret;

  logic [7:0]  ack_lat;
  logic [7:0]  wait_cnt = 8'd0;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  exp_t exp_q[$];

  pc_seq_ctrl_if imem();

  pc_seq_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_we           (pc_we),
    .imem            (imem),
    .instr_valid     (instr_valid),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .mret            (mret),
    .mepc            (mepc),
    .mcause          (mcause),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  // pc_reg and an instruction memory that acks after ack_lat wait cycles
  always @(posedge clk) begin
    pc       <= pc_next;
    wait_cnt <= (imem.req && !imem.ack && !pc_we) ? 8'(wait_cnt + 8'd1) : 8'd0;
  end
  assign imem.ack = imem.req && (wait_cnt == ack_lat);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a fetch starts when req rises or a PC update lands during FETCH
  initial begin
    logic prev_req = 1'b0;
    logic prev_we  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (pc_we) we_cnt++;
      if (imem.req && (!prev_req || prev_we)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fetch", imem.addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_addr", imem.addr, e.addr);
          chk("fetch_mepc", mepc, e.mepc);
          chk("fetch_mcause", 32'(mcause), 32'(e.mcause));
          chk("fetch_instret", instret, e.instret);
        end
      end
      prev_req = imem.req;
      prev_we  = pc_we;
    end
  end

  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] m,
                              input logic [3:0] c, input logic [31:0] n);
    exp_t e;
    e.addr = a; e.mepc = m; e.mcause = c; e.instret = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_exec();
    for (int i = 0; i < 100; i++) begin
      if (instr_valid) return;
      @(negedge clk);
    end
    chk("exec_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  // One EXEC cycle with the given decode inputs
  task automatic exec_op(input logic t, input logic m, input logic r, input logic [31:0] tgt);
    trap_req = t; mret = m; redirect = r; redirect_target = tgt;
    #1;
    chk("exec_pc_we", {31'd0, pc_we}, 32'd1);
    @(negedge clk);
    trap_req = 1'b0; mret = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
  endtask

  initial begin
    int n;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; trap_req = 1'b0; mret = 1'b0;
    redirect_target = 32'h0; ack_lat = 8'd1;

    // Reset for 3 cycles; outputs quiet and pc held
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem.req}, 32'd0);
    chk("rst_we", {31'd0, pc_we}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_next", pc_next, pc);
    chk("rst_instret", instret, 32'd0);
    expect_fetch(32'h0, 32'h0, 4'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rststate_we", {31'd0, pc_we}, 32'd1);
    chk("rststate_pc_next", pc_next, 32'h0);
    @(negedge clk);

    // Sequential 0,4,8,C
    wait_exec(); expect_fetch(32'h4, 32'h0, 4'd0, 32'd1); exec_op(0, 0, 0, 0);
    wait_exec(); expect_fetch(32'h8, 32'h0, 4'd0, 32'd2); exec_op(0, 0, 0, 0);
    wait_exec(); expect_fetch(32'hC, 32'h0, 4'd0, 32'd3); exec_op(0, 0, 0, 0);
    chk("we_pulses", 32'(we_cnt), 32'd4);

    // Aligned redirect, then misaligned redirect traps
    wait_exec(); expect_fetch(32'h40, 32'h0, 4'd0, 32'd4); exec_op(0, 0, 1, 32'h40);
    wait_exec(); expect_fetch(32'h100, 32'h40, 4'd0, 32'd4); exec_op(0, 0, 1, 32'h42);

    // trap_req beats redirect, then mret returns
    wait_exec(); expect_fetch(32'h10, 32'h40, 4'd0, 32'd5); exec_op(0, 0, 1, 32'h10);
    wait_exec(); expect_fetch(32'h100, 32'h10, 4'd2, 32'd5); exec_op(1, 0, 1, 32'h80);
    wait_exec(); expect_fetch(32'h10, 32'h10, 4'd2, 32'd6); exec_op(0, 1, 0, 0);

    // Fetch timeout at 0x20: trap on the 16th FETCH cycle
    wait_exec();
    ack_lat = 8'd255;
    expect_fetch(32'h20, 32'h10, 4'd2, 32'd7);
    expect_fetch(32'h100, 32'h20, 4'd1, 32'd7);
    exec_op(0, 0, 1, 32'h20);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (pc == 32'h100) break;
      if (imem.req) n++;
      @(negedge clk);
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    ack_lat = 8'd1;

    // Ack on exactly the 16th cycle wins over the timeout
    wait_exec();
    ack_lat = 8'd15;
    expect_fetch(32'h20, 32'h20, 4'd1, 32'd8);
    exec_op(0, 0, 1, 32'h20);
    wait_exec();
    chk("ack_wins_pc", pc, 32'h20);
    ack_lat = 8'd1;
    expect_fetch(32'h24, 32'h20, 4'd1, 32'd9);
    exec_op(0, 0, 0, 0);

    // Stall for 5 cycles at 0x24
    wait_exec();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_pc_next", pc_next, pc);
      chk("stall_we", {31'd0, pc_we}, 32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      @(negedge clk);
    end
    stall = 1'b0;
    expect_fetch(32'h28, 32'h20, 4'd1, 32'd10);
    #1;
    chk("unstall_pc_next", pc_next, 32'h28);
    @(negedge clk);

    // Reset in the middle of a fetch at 0x30
    wait_exec();
    ack_lat = 8'd200;
    expect_fetch(32'h30, 32'h20, 4'd1, 32'd11);
    exec_op(0, 0, 1, 32'h30);
    for (int i = 0; i < 10; i++) begin
      if (pc == 32'h30) break;
      @(negedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    expect_fetch(32'h0, 32'h0, 4'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_req", {31'd0, imem.req}, 32'd0);
    chk("midrst_pc_next", pc_next, 32'h30);
    chk("midrst_mepc", mepc, 32'h0);
    chk("midrst_mcause", 32'(mcause), 32'd0);
    chk("midrst_instret", instret, 32'd0);
    ack_lat = 8'd1;
    @(negedge clk);
    reset = 1'b0;
    wait_exec(); expect_fetch(32'h4, 32'h0, 4'd0, 32'd1); exec_op(0, 0, 0, 0);

    // Drain the scoreboard
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
